// File: rtl/shadow_reg_pkg.sv
// Shared types for the shadow register bank.
// Holds the commit FSM state encoding and the operating mode constants.
package shadow_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int MODE_TRANSPARENT = 0;
    localparam int MODE_SHADOW      = 1;

endpackage

// File: rtl/shadow_reg_cell.sv
// One channel of the bank: staging register, active register and pending flag.
// In transparent mode the staging copy is bypassed and writes hit q directly.
module shadow_reg_cell #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shadow,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] d,
    input  logic             take,
    output logic [WIDTH-1:0] q,
    output logic             pending
);

    logic [WIDTH-1:0] staging;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            staging <= RESET_VAL;
            q       <= RESET_VAL;
            pending <= 1'b0;
        end else if (clear) begin
            staging <= RESET_VAL;
            q       <= RESET_VAL;
            pending <= 1'b0;
        end else if (!shadow) begin
            if (wr_en) begin
                q <= d;
            end
        end else begin
            // A write on the commit edge lands after the transfer, so it
            // re-arms this channel for the following commit.
            if (take && pending) begin
                q       <= staging;
                pending <= 1'b0;
            end
            if (wr_en) begin
                staging <= d;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/shadow_register_bank.sv
// Multi-channel register bank with optional double-buffered atomic commit.
// Top holds the commit FSM and counter; channels live in shadow_reg_cell.
module shadow_register_bank
    import shadow_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               CHANNELS  = 2,
    parameter int               SHADOW    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       wr_en,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic                      commit,
    input  logic                      clear,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       pending,
    output logic                      commit_done,
    output logic [CNT_W-1:0]          commit_cnt,
    output logic [1:0]                fsm_state
);

    localparam logic SHADOW_ON = (SHADOW == MODE_SHADOW);

    state_t state;
    logic   take;

    // A commit only counts when something is staged; clear overrides it.
    assign take      = SHADOW_ON && commit && !clear && (|pending);
    assign fsm_state = state;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        shadow_reg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .shadow  (SHADOW_ON),
            .wr_en   (wr_en[i]),
            .d       (d[i*WIDTH +: WIDTH]),
            .take    (take),
            .q       (q[i*WIDTH +: WIDTH]),
            .pending (pending[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            commit_done <= 1'b0;
            commit_cnt  <= '0;
        end else if (clear) begin
            state       <= IDLE;
            commit_done <= 1'b0;
        end else if (SHADOW_ON) begin
            commit_done <= take;
            if (take) begin
                state      <= COMMIT;
                commit_cnt <= commit_cnt + CNT_W'(1);
            end else begin
                case (state)
                    IDLE:    if (|wr_en) state <= ARMED;
                    ARMED:   state <= ARMED;
                    COMMIT:  state <= ((|wr_en) || (|pending)) ? ARMED : IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shadow_register_bank.sv
// Bench for shadow_register_bank: shadow bank (CNT_W 8 and 2 sharing stimulus)
// plus a 4x16 transparent bank, checked against an array-based reference.
module tb_shadow_register_bank;
  import shadow_reg_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // shadow banks (u_sh CNT_W=8, u_wr CNT_W=2) share inputs
  logic [1:0]  wr_en;
  logic [15:0] d;
  logic        commit, clear;
  logic [15:0] q_s, q_w;
  logic [1:0]  pend_s, pend_w, st_s, st_w;
  logic        done_s, done_w;
  logic [7:0]  cnt_s;
  logic [1:0]  cnt_w;

  // transparent bank
  logic [3:0]  t_wr;
  logic [63:0] t_d;
  logic        t_commit, t_clear;
  logic [63:0] t_q;
  logic [3:0]  t_pend;
  logic        t_done;
  logic [7:0]  t_cnt;
  logic [1:0]  t_st;

  shadow_register_bank #(.WIDTH(8), .CHANNELS(2), .SHADOW(1), .CNT_W(8)) u_sh (
    .clk(clk), .rst(rst), .wr_en(wr_en), .d(d), .commit(commit), .clear(clear),
    .q(q_s), .pending(pend_s), .commit_done(done_s), .commit_cnt(cnt_s), .fsm_state(st_s));

  shadow_register_bank #(.WIDTH(8), .CHANNELS(2), .SHADOW(1), .CNT_W(2)) u_wr (
    .clk(clk), .rst(rst), .wr_en(wr_en), .d(d), .commit(commit), .clear(clear),
    .q(q_w), .pending(pend_w), .commit_done(done_w), .commit_cnt(cnt_w), .fsm_state(st_w));

  shadow_register_bank #(.WIDTH(16), .CHANNELS(4), .SHADOW(0), .CNT_W(8)) u_tr (
    .clk(clk), .rst(rst), .wr_en(t_wr), .d(t_d), .commit(t_commit), .clear(t_clear),
    .q(t_q), .pending(t_pend), .commit_done(t_done), .commit_cnt(t_cnt), .fsm_state(t_st));

  // reference model
  logic [7:0]  m_stage[2];
  logic [7:0]  m_act[2];
  logic [1:0]  m_pend;
  logic        m_done;
  int          m_cnt;
  logic [15:0] m_tact[4];

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin m_stage[i] = '0; m_act[i] = '0; end
    for (int i = 0; i < 4; i++) m_tact[i] = '0;
    m_pend = '0;
    m_done = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_edge();
    logic take;
    if (rst) begin
      reset_model();
      return;
    end
    if (clear) begin
      for (int i = 0; i < 2; i++) begin m_stage[i] = '0; m_act[i] = '0; end
      m_pend = '0;
      m_done = 1'b0;
    end else begin
      take   = commit && (m_pend != 0);
      m_done = take;
      if (take) begin
        for (int i = 0; i < 2; i++) if (m_pend[i]) m_act[i] = m_stage[i];
        m_pend = '0;
        m_cnt++;
      end
      for (int i = 0; i < 2; i++)
        if (wr_en[i]) begin m_stage[i] = d[i*8 +: 8]; m_pend[i] = 1'b1; end
    end
    if (t_clear) begin
      for (int i = 0; i < 4; i++) m_tact[i] = '0;
    end else begin
      for (int i = 0; i < 4; i++) if (t_wr[i]) m_tact[i] = t_d[i*16 +: 16];
    end
  endtask

  task automatic check_all();
    logic [1:0] m_state;
    m_state = m_done ? COMMIT : ((m_pend != 0) ? ARMED : IDLE);
    check("sh_q", 64'(q_s), 64'({m_act[1], m_act[0]}));
    check("sh_pending", 64'(pend_s), 64'(m_pend));
    check("sh_done", 64'(done_s), 64'(m_done));
    check("sh_cnt", 64'(cnt_s), 64'(m_cnt[7:0]));
    check("sh_state", 64'(st_s), 64'(m_state));
    check("wr_q", 64'(q_w), 64'({m_act[1], m_act[0]}));
    check("wr_done", 64'(done_w), 64'(m_done));
    check("wr_cnt", 64'(cnt_w), 64'(m_cnt[1:0]));
    check("tr_q", t_q, {m_tact[3], m_tact[2], m_tact[1], m_tact[0]});
    check("tr_pending", 64'(t_pend), 64'd0);
    check("tr_done", 64'(t_done), 64'd0);
    check("tr_cnt", 64'(t_cnt), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic [1:0] w, input logic [7:0] a, input logic [7:0] b,
                       input logic cm, input logic cl);
    wr_en = w; d = {b, a}; commit = cm; clear = cl;
  endtask

  task automatic t_drive(input logic [3:0] w, input logic [63:0] v, input logic cm, input logic cl);
    t_wr = w; t_d = v; t_commit = cm; t_clear = cl;
  endtask

  initial begin
    // 1: reset dominates active writes
    rst = 1'b1;
    reset_model();
    drive(2'b11, 8'h01, 8'h01, 1'b0, 1'b0);
    t_drive(4'b1111, {4{16'h5555}}, 1'b0, 1'b0);
    #1;
    check_all();
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 1'b0, 1'b0);
    t_drive(4'b0000, 64'h0, 1'b0, 1'b0);
    step();

    // 2: staged write then commit
    drive(2'b11, 8'd52, 8'd45, 1'b0, 1'b0);
    step();
    check("t2_q_held", 64'(q_s), 64'h0);
    check("t2_pending", 64'(pend_s), 64'b11);
    drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    step();
    check("t2_q_commit", 64'(q_s), 64'({8'd45, 8'd52}));
    check("t2_done", 64'(done_s), 64'd1);
    check("t2_cnt", 64'(cnt_s), 64'd1);
    drive(2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    step();

    // 3: partial update, then commit with nothing pending
    drive(2'b01, 8'd11, 8'd0, 1'b0, 1'b0);
    step();
    drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    step();
    check("t3_q_partial", 64'(q_s), 64'({8'd45, 8'd11}));
    drive(2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    step();
    drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    step();
    check("t3_empty_done", 64'(done_s), 64'd0);
    check("t3_empty_cnt", 64'(cnt_s), 64'd2);

    // 4: commit with concurrent write, back-to-back commit, clear over everything
    drive(2'b11, 8'd36, 8'd9, 1'b0, 1'b0);
    step();
    drive(2'b01, 8'd63, 8'd0, 1'b1, 1'b0);
    step();
    check("t4_q_old_stage", 64'(q_s), 64'({8'd9, 8'd36}));
    check("t4_pending_new", 64'(pend_s), 64'b01);
    drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    step();
    check("t4_q_b2b", 64'(q_s), 64'({8'd9, 8'd63}));
    drive(2'b11, 8'd5, 8'd6, 1'b1, 1'b1);
    step();
    check("t4_clear_q", 64'(q_s), 64'h0);
    check("t4_clear_cnt", 64'(cnt_s), 64'd4);
    drive(2'b00, 8'd0, 8'd0, 1'b0, 1'b0);

    // 5: transparent bank, commit ignored
    t_drive(4'b0101, {16'h0, 16'hBEEF, 16'h0, 16'h1234}, 1'b1, 1'b0);
    step();
    check("t5_q", t_q, 64'h0000_BEEF_0000_1234);
    check("t5_cnt", 64'(t_cnt), 64'd0);
    t_drive(4'b0000, 64'h0, 1'b0, 1'b0);
    step();

    // 6a: async reset between edges while in COMMIT
    drive(2'b11, 8'hA5, 8'h5A, 1'b0, 1'b0);
    step();
    drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
    step();
    check("t6_in_commit", 64'(done_s), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    reset_model();
    check_all();
    check("t6_async_q", 64'(q_s), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    step();

    // 6b: counter wrap on the 2-bit instance
    for (int k = 0; k < 4; k++) begin
      drive(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 1'b0, 1'b0);
      step();
      drive(2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
      step();
      check("t6_wrap_cnt", 64'(cnt_w), 64'((k + 1) % 4));
    end
    drive(2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
    step();

    // randomized traffic on both banks
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 19) == 0));
      t_drive(4'($urandom_range(0, 15)), {$urandom, $urandom},
              ($urandom_range(0, 1) == 0), ($urandom_range(0, 19) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/shadow_register_bank.md
Name: shadow_register_bank

Overview:
- Parametrised, multi-channel successor to the twin 8-bit register.
- Holds CHANNELS independent WIDTH-bit registers, each with per-channel load enable.
- Optional shadow (double-buffered) mode: writes land in a staging copy and move to the outputs together on a commit pulse.
- Used wherever several datapath values must update atomically, e.g. coefficient sets or configuration words.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 2, number of channels (1..16).
- SHADOW, 1, 1 = staged writes with atomic commit; 0 = transparent (write goes straight to output next edge).
- RESET_VAL, 0, value loaded into every staging and active register on reset or clear.
- CNT_W, 8, width of the commit counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- wr_en  input  CHANNELS  per-channel write enable; bit i selects channel i.
- d  input  CHANNELS*WIDTH  write data; channel i occupies d[i*WIDTH +: WIDTH].
- commit  input  1  single-cycle request to transfer all pending staging values to outputs (SHADOW=1 only).
- clear  input  1  synchronous clear of all registers to RESET_VAL.
- q  output  CHANNELS*WIDTH  active register values, same packing as d.
- pending  output  CHANNELS  channel staged but not yet committed.
- commit_done  output  1  one-cycle pulse, cycle after a commit takes effect.
- commit_cnt  output  CNT_W  number of effective commits, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate):
  - q = RESET_VAL on all channels; staging = RESET_VAL.
  - pending = 0, commit_done = 0, commit_cnt = 0.
  - FSM to IDLE.
- Priority per edge: clear > commit > write.
- clear:
  - Same values as reset except commit_cnt, which is held.
  - Writes and commit in the same cycle are discarded.
  - commit_done = 0.
- SHADOW=0:
  - wr_en[i] loads d channel i into q channel i at the next edge (1-cycle latency).
  - pending, commit_done and commit_cnt stay 0; commit is ignored.
- SHADOW=1, write: wr_en[i] loads staging[i] and sets pending[i]. Repeated writes before a commit overwrite staging; last value wins.
- SHADOW=1, FSM states:
  - IDLE (pending == 0): commit ignored, no pulse, counter unchanged. Any write -> ARMED.
  - ARMED (pending != 0): commit -> COMMIT.
  - COMMIT (lasts exactly 1 cycle):
    - At the entering edge, q[i] <= staging[i] for every pending channel; non-pending channels keep q.
    - pending cleared; commit_cnt increments.
    - commit_done = 1 during this state.
    - Next state is ARMED if a write arrived during COMMIT, otherwise IDLE.
- Write and commit in the same cycle:
  - Commit uses staging values from before that edge.
  - The new write lands in staging with pending[i] = 1 for the next commit.
  - FSM goes to COMMIT and then ARMED.
- Back-to-back commits (COMMIT state with commit high): honoured only if pending != 0 at that edge; otherwise ignored.
- Commit latency: q visible 1 cycle after the commit edge; commit_done is high in the same cycle q changes.
- commit_cnt wraps 2^CNT_W-1 -> 0 with no flag.
- Reset asserted mid-COMMIT: all outputs go to reset values immediately; the commit is lost.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Shared package shadow_reg_pkg:
  - FSM state typedef: IDLE, ARMED, COMMIT.
  - Mode constants MODE_TRANSPARENT = 0, MODE_SHADOW = 1.
- One sub-module: shadow_reg_cell (WIDTH, RESET_VAL), one channel holding its staging register, active register and pending bit.
  - Instanced CHANNELS times by generate.
  - Top level holds the FSM and commit counter.

Test Plan:
1. Reset, WIDTH=8, CHANNELS=2, SHADOW=1: rst=1 with d=8'h01/8'h01 and wr_en=2'b11 -> q=0/0, pending=0, commit_cnt=0.
2. Staged write: wr_en=2'b11, d=52/45 for 1 cycle -> q stays 0/0, pending=2'b11. Then commit=1 -> next cycle q=52/45, commit_done=1, commit_cnt=1, pending=0.
3. Partial update: write channel 0 only with 11, commit -> q=11/45. Then commit with nothing pending -> no commit_done, commit_cnt unchanged at 2.
4. Simultaneous events:
   - Staging holds 36/9 (pending=2'b11); same cycle assert commit plus wr_en=2'b01 with d0=63 -> q=36/9, pending=2'b01.
   - Second commit -> q=63/9.
   - clear with commit and write together -> q=0/0, pending=0, commit_cnt held.
5. SHADOW=0, CHANNELS=4, WIDTH=16: wr_en=4'b0101, d ch0=16'h1234, ch2=16'hBEEF -> next edge q ch0=16'h1234, ch2=16'hBEEF, ch1/ch3=0; commit ignored.
6. Counter wrap, CNT_W=2: four effective commits -> commit_cnt 1,2,3,0. Async rst pulsed between edges mid-COMMIT -> outputs reset immediately.
